// File: rtl/data_mem_arbiter_pkg.sv
// Shared definitions for the data memory arbiter: sizing defaults, FSM
// encoding and the port identifiers used to index the two requesters.
package dmem_arb_pkg;

  localparam int DEPTH_DEF = 256;
  localparam int DW_DEF    = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of core port, DMA port and memory-side signals for the arbiter.
// slave = arbiter side, master = requesters plus the memory model.
interface data_mem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic          c_req;
  logic          c_we;
  logic [DW-1:0] c_addr;
  logic [DW-1:0] c_wdata;
  logic          c_gnt;
  logic          c_rvalid;
  logic          c_err;
  logic [DW-1:0] c_rdata;

  logic          d_req;
  logic          d_we;
  logic [DW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt;
  logic          d_rvalid;
  logic          d_err;
  logic [DW-1:0] d_rdata;

  logic          mem_we;
  logic [DW-1:0] mem_a;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          init_busy;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    output c_gnt, c_rvalid, c_err, c_rdata,
    input  d_req, d_we, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_err, d_rdata,
    output mem_we, mem_a, mem_wd,
    input  mem_rd,
    output init_busy
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    input  c_gnt, c_rvalid, c_err, c_rdata,
    output d_req, d_we, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_err, d_rdata,
    input  mem_we, mem_a, mem_wd,
    output mem_rd,
    input  init_busy
  );

endinterface

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-way round-robin decision: on a tie the port that did not win last time
// is granted. Purely combinational; the pointer lives in the parent.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == PORT_DMA) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Core/DMA data memory arbiter: clears the memory after reset, then serves
// one access per cycle with round-robin arbitration and 1-cycle responses.
module data_mem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int DW    = DW_DEF
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam int            CW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [DW-1:0] DEPTH_W  = DW'(DEPTH);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [1:0]           rvalid_q, rvalid_d;
  logic [1:0]           err_q, err_d;
  logic [1:0][DW-1:0]   rdata_q, rdata_d;

  logic [1:0]           req, gnt;
  logic                 acc, acc_port, acc_we, acc_inr;
  logic [DW-1:0]        acc_addr, acc_wdata, rsp_data;
  logic                 mem_we_c;
  logic [DW-1:0]        mem_a_c, mem_wd_c;

  // Requests are masked during the sweep so nothing is granted until RUN.
  assign req = (state_q == RUN) ? {bus.d_req, bus.c_req} : 2'b00;

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_q),
    .gnt        (gnt)
  );

  assign acc       = |gnt;
  assign acc_port  = gnt[PORT_DMA] ? PORT_DMA : PORT_CORE;
  assign acc_we    = (acc_port == PORT_DMA) ? bus.d_we    : bus.c_we;
  assign acc_addr  = (acc_port == PORT_DMA) ? bus.d_addr  : bus.c_addr;
  assign acc_wdata = (acc_port == PORT_DMA) ? bus.d_wdata : bus.c_wdata;
  assign acc_inr   = (acc_addr < DEPTH_W);
  assign rsp_data  = acc_inr ? bus.mem_rd : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= INIT;
      cnt_q    <= '0;
      last_q   <= PORT_DMA;
      rvalid_q <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      last_q   <= last_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    rvalid_d = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    mem_we_c = 1'b0;
    mem_a_c  = '0;
    mem_wd_c = '0;
    unique case (state_q)
      INIT: begin
        mem_we_c = 1'b1;
        mem_a_c  = DW'(cnt_q);
        if (cnt_q == CNT_LAST) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (acc) begin
          last_d             = acc_port;
          rvalid_d[acc_port] = !acc_we;
          err_d[acc_port]    = !acc_inr;
          if (!acc_we) rdata_d[acc_port] = rsp_data;
          if (acc_inr) begin
            mem_a_c = acc_addr;
            if (acc_we) begin
              mem_we_c = 1'b1;
              mem_wd_c = acc_wdata;
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  assign bus.c_gnt    = gnt[PORT_CORE];
  assign bus.d_gnt    = gnt[PORT_DMA];
  assign bus.c_rvalid = rvalid_q[PORT_CORE];
  assign bus.d_rvalid = rvalid_q[PORT_DMA];
  assign bus.c_err    = err_q[PORT_CORE];
  assign bus.d_err    = err_q[PORT_DMA];
  assign bus.c_rdata  = rdata_q[PORT_CORE];
  assign bus.d_rdata  = rdata_q[PORT_DMA];

  // INIT drives a write even while held in reset; rst masks it so every
  // output reads 0 until reset is released.
  assign bus.mem_we    = mem_we_c & rst;
  assign bus.mem_a     = mem_a_c;
  assign bus.mem_wd    = mem_wd_c;
  assign bus.init_busy = (state_q == INIT) & rst;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model of the arbitration and memory contents.
module tb_data_mem_arbiter;
  import dmem_arb_pkg::*;

  localparam int DEPTH = 256;
  localparam int DW    = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  data_mem_arbiter_if #(.DW(DW)) bus ();

  data_mem_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Attached memory: combinational read, synchronous write.
  logic [31:0] ram [DEPTH];
  assign bus.mem_rd = (bus.mem_a < DEPTH) ? ram[bus.mem_a[7:0]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (bus.mem_we && bus.mem_a < DEPTH) ram[bus.mem_a[7:0]] <= bus.mem_wd;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  int          last_win;
  logic [31:0] exp_rdata [2];

  function automatic int pick(input bit cr, input bit dr, input int last);
    if (cr && dr) return (last == 1) ? 0 : 1;
    if (cr) return 0;
    if (dr) return 1;
    return -1;
  endfunction

  function automatic logic [135:0] all_outs();
    return {bus.c_gnt, bus.c_rvalid, bus.c_err, bus.c_rdata,
            bus.d_gnt, bus.d_rvalid, bus.d_err, bus.d_rdata,
            bus.mem_we, bus.mem_a, bus.mem_wd, bus.init_busy};
  endfunction

  task automatic idle_inputs();
    bus.c_req = 1'b0; bus.c_we = 1'b0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
  endtask

  task automatic model_cleared();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
    last_win     = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.c_req = 1'b1;
    rst = 1'b0;
    #12;
    checks++;
    if (all_outs() !== 136'h0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0", all_outs());
    end
  endtask

  task automatic test_init_sweep();
    logic [67:0] obs, exp;
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      obs = {bus.init_busy, bus.mem_we, bus.mem_a, bus.mem_wd, bus.c_gnt, bus.d_gnt};
      exp = {1'b1, 1'b1, 32'(i), 32'h0, 1'b0, 1'b0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL init_sweep word %0d: got %h expected %h", i, obs, exp);
      end
      @(negedge clk); #1;
    end
    checks++;
    if ({bus.init_busy, bus.mem_we, bus.c_gnt, bus.d_gnt} !== 4'b0010) begin
      errors++;
      $display("FAIL first_run_cycle: busy/we/cgnt/dgnt got %b expected 0010",
               {bus.init_busy, bus.mem_we, bus.c_gnt, bus.d_gnt});
    end
    bus.c_req = 1'b0;
    model_cleared();
  endtask

  task automatic test_write_then_read();
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b1; bus.c_addr = 32'h10; bus.c_wdata = 32'hDEADBEEF;
    #1;
    checks++;
    if ({bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_a, bus.mem_wd} !== {3'b101, 32'h10, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL core_write: got %h expected %h",
               {bus.c_gnt, bus.d_gnt, bus.mem_we, bus.mem_a, bus.mem_wd}, {3'b101, 32'h10, 32'hDEADBEEF});
    end
    ref_mem[16] = 32'hDEADBEEF; last_win = 0;
    @(negedge clk);
    checks++;
    if ({bus.c_rvalid, bus.c_err} !== 2'b00) begin
      errors++;
      $display("FAIL write_no_resp: c_rvalid/c_err got %b expected 00", {bus.c_rvalid, bus.c_err});
    end
    bus.c_req = 1'b0;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h10;
    #1;
    checks++;
    if ({bus.d_gnt, bus.c_gnt, bus.mem_we, bus.mem_a} !== {3'b100, 32'h10}) begin
      errors++;
      $display("FAIL dma_read_grant: got %h expected %h", {bus.d_gnt, bus.c_gnt, bus.mem_we, bus.mem_a}, {3'b100, 32'h10});
    end
    last_win = 1;
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.c_rvalid, bus.d_rdata} !== {3'b100, ref_mem[16]}) begin
      errors++;
      $display("FAIL raw_read_resp: got %h expected %h", {bus.d_rvalid, bus.d_err, bus.c_rvalid, bus.d_rdata}, {3'b100, ref_mem[16]});
    end
    exp_rdata[1] = ref_mem[16];
    bus.d_req = 1'b0;
    #1;
    checks++;
    if ({bus.mem_we, bus.mem_a, bus.mem_wd} !== 65'h0) begin
      errors++;
      $display("FAIL idle_mem: got %h expected 0", {bus.mem_we, bus.mem_a, bus.mem_wd});
    end
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.d_rdata} !== {1'b0, exp_rdata[1]}) begin
      errors++;
      $display("FAIL rdata_hold: got %h expected %h", {bus.d_rvalid, bus.d_rdata}, {1'b0, exp_rdata[1]});
    end
  endtask

  task automatic test_round_robin();
    int prev = -1;
    int win;
    logic [31:0] raddr [2];
    raddr[0] = 32'h10; raddr[1] = 32'h20;
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = raddr[0];
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = raddr[1];
    for (int k = 0; k <= 6; k++) begin
      checks++;
      if (prev < 0) begin
        if ({bus.c_rvalid, bus.d_rvalid} !== 2'b00) begin
          errors++;
          $display("FAIL rr_resp k=%0d: rvalid c/d got %b expected 00", k, {bus.c_rvalid, bus.d_rvalid});
        end
      end else begin
        exp_rdata[prev] = ref_mem[raddr[prev][7:0]];
        if ({bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata} !==
            {prev == 0, prev == 1, exp_rdata[0], exp_rdata[1]}) begin
          errors++;
          $display("FAIL rr_resp k=%0d: got %h expected %h", k,
                   {bus.c_rvalid, bus.d_rvalid, bus.c_rdata, bus.d_rdata},
                   {prev == 0, prev == 1, exp_rdata[0], exp_rdata[1]});
        end
      end
      if (k == 6) break;
      #1;
      win = (k % 2 == 0) ? 0 : 1;
      checks++;
      if ({bus.c_gnt, bus.d_gnt} !== {win == 0, win == 1}) begin
        errors++;
        $display("FAIL rr_grant k=%0d: c/d got %b expected %b", k, {bus.c_gnt, bus.d_gnt}, {win == 0, win == 1});
      end
      last_win = win; prev = win;
      @(negedge clk);
    end
    idle_inputs();
  endtask

  task automatic test_out_of_range();
    @(negedge clk);
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h100; bus.d_wdata = 32'h1234;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b10) begin
      errors++;
      $display("FAIL oor_write_grant: gnt/we got %b expected 10", {bus.d_gnt, bus.mem_we});
    end
    last_win = 1;
    @(negedge clk);
    checks++;
    if ({bus.d_err, bus.d_rvalid, bus.d_rdata} !== {2'b10, exp_rdata[1]}) begin
      errors++;
      $display("FAIL oor_write_err: got %h expected %h", {bus.d_err, bus.d_rvalid, bus.d_rdata}, {2'b10, exp_rdata[1]});
    end
    bus.d_we = 1'b0;
    #1;
    checks++;
    if ({bus.d_gnt, bus.mem_we} !== 2'b10) begin
      errors++;
      $display("FAIL oor_read_grant: gnt/we got %b expected 10", {bus.d_gnt, bus.mem_we});
    end
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.d_err, bus.d_rdata} !== {2'b11, 32'h0}) begin
      errors++;
      $display("FAIL oor_read_resp: got %h expected %h", {bus.d_rvalid, bus.d_err, bus.d_rdata}, {2'b11, 32'h0});
    end
    exp_rdata[1] = 32'h0;
    bus.d_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.d_rvalid, bus.d_err} !== 2'b00) begin
      errors++;
      $display("FAIL oor_pulse_width: rvalid/err got %b expected 00", {bus.d_rvalid, bus.d_err});
    end
  endtask

  task automatic test_random_traffic();
    bit          p_req [2];
    bit          p_we [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wd [2];
    bit          hold [2];
    bit          exp_rv [2];
    bit          exp_er [2];
    int          win;
    bit          inr;
    logic [64:0] obs, exp, msk;
    for (int p = 0; p < 2; p++) begin
      hold[p] = 0; exp_rv[p] = 0; exp_er[p] = 0;
    end
    for (int n = 0; n <= 300; n++) begin
      @(negedge clk);
      checks++;
      if ({bus.c_rvalid, bus.c_err, bus.c_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata} !==
          {exp_rv[0], exp_er[0], exp_rdata[0], exp_rv[1], exp_er[1], exp_rdata[1]}) begin
        errors++;
        $display("FAIL rand_resp n=%0d: got %h expected %h", n,
                 {bus.c_rvalid, bus.c_err, bus.c_rdata, bus.d_rvalid, bus.d_err, bus.d_rdata},
                 {exp_rv[0], exp_er[0], exp_rdata[0], exp_rv[1], exp_er[1], exp_rdata[1]});
      end
      if (n == 300) break;
      for (int p = 0; p < 2; p++) begin
        if (!hold[p]) begin
          p_req[p]  = ($urandom_range(0, 3) != 0);
          p_we[p]   = $urandom_range(0, 1) == 1;
          p_addr[p] = ($urandom_range(0, 7) == 0) ? 32'(DEPTH + $urandom_range(0, 1000))
                                                  : 32'($urandom_range(0, 15));
          p_wd[p]   = $urandom;
        end
      end
      bus.c_req = p_req[0]; bus.c_we = p_we[0]; bus.c_addr = p_addr[0]; bus.c_wdata = p_wd[0];
      bus.d_req = p_req[1]; bus.d_we = p_we[1]; bus.d_addr = p_addr[1]; bus.d_wdata = p_wd[1];
      #1;
      win = pick(p_req[0], p_req[1], last_win);
      exp = '0; msk = {1'b1, 32'h0, 32'h0};
      if (win < 0) begin
        msk = '1;
      end else begin
        inr = p_addr[win] < DEPTH;
        if (inr) begin
          exp = {p_we[win], p_addr[win], p_we[win] ? p_wd[win] : 32'h0};
          msk = {1'b1, 32'hFFFF_FFFF, p_we[win] ? 32'hFFFF_FFFF : 32'h0};
        end
      end
      obs = {bus.mem_we, bus.mem_a, bus.mem_wd};
      checks++;
      if ({bus.c_gnt, bus.d_gnt, obs & msk} !== {win == 0, win == 1, exp & msk}) begin
        errors++;
        $display("FAIL rand_grant n=%0d: got %h expected %h", n,
                 {bus.c_gnt, bus.d_gnt, obs & msk}, {win == 0, win == 1, exp & msk});
      end
      for (int p = 0; p < 2; p++) begin
        exp_rv[p] = 0; exp_er[p] = 0;
        hold[p]   = p_req[p] && (p != win);
      end
      if (win >= 0) begin
        last_win = win;
        inr = p_addr[win] < DEPTH;
        exp_rv[win] = !p_we[win];
        exp_er[win] = !inr;
        if (!p_we[win]) exp_rdata[win] = inr ? ref_mem[p_addr[win][7:0]] : 32'h0;
        if (p_we[win] && inr) ref_mem[p_addr[win][7:0]] = p_wd[win];
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_sweep();
    logic [33:0] obs, exp;
    @(negedge clk);
    bus.c_req = 1'b1; bus.c_we = 1'b0; bus.c_addr = 32'h10;
    @(posedge clk);
    #2;
    rst = 1'b0;
    idle_inputs();
    #1;
    checks++;
    if (all_outs() !== 136'h0) begin
      errors++;
      $display("FAIL reset_mid_txn: got %h expected 0", all_outs());
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i <= 100; i++) begin
      obs = {bus.init_busy, bus.mem_we, bus.mem_a};
      exp = {2'b11, 32'(i)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL presweep word %0d: got %h expected %h", i, obs, exp);
      end
      if (i < 100) begin
        @(negedge clk); #1;
      end
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (all_outs() !== 136'h0) begin
      errors++;
      $display("FAIL reset_mid_sweep: got %h expected 0", all_outs());
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    for (int i = 0; i < DEPTH; i++) begin
      obs = {bus.init_busy, bus.mem_we, bus.mem_a};
      exp = {2'b11, 32'(i)};
      checks++;
      if (obs !== exp || bus.mem_wd !== 32'h0) begin
        errors++;
        $display("FAIL resweep word %0d: got %h/%h expected %h/0", i, obs, bus.mem_wd, exp);
      end
      @(negedge clk); #1;
    end
    model_cleared();
    bus.c_req = 1'b1; bus.c_addr = 32'h1;
    bus.d_req = 1'b1; bus.d_addr = 32'h2;
    #1;
    checks++;
    if ({bus.init_busy, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid} !== 5'b01000) begin
      errors++;
      $display("FAIL post_reset_tie: busy/cg/dg/crv/drv got %b expected 01000",
               {bus.init_busy, bus.c_gnt, bus.d_gnt, bus.c_rvalid, bus.d_rvalid});
    end
    idle_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] <= $urandom;
    idle_inputs();
    test_reset();
    test_init_sweep();
    test_write_then_read();
    test_round_robin();
    test_out_of_range();
    test_random_traffic();
    test_reset_mid_sweep();
    test_random_traffic();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter DEPTH, default 256: number of 32-bit words in the attached data memory.
REQ-002 Parameter DW, default 32: data and address width.
REQ-003 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 c_req/c_we  input  1/1  core port: request valid / write (1) or read (0).
REQ-006 c_addr/c_wdata  input  DW/DW  core port: word address / write data.
REQ-007 c_gnt  output  1  core request accepted this cycle.
REQ-008 c_rvalid/c_err  output  1/1  core response valid / access error.
REQ-009 c_rdata  output  DW  core read data.
REQ-010 d_req, d_we, d_addr, d_wdata, d_gnt, d_rvalid, d_err, d_rdata: DMA port, same directions, widths and meanings as the core port.
REQ-011 mem_we  output  1  write enable to data memory.
REQ-012 mem_a/mem_wd  output  DW/DW  memory word address / write data.
REQ-013 mem_rd  input  DW  memory combinational read data for mem_a.
REQ-014 init_busy  output  1  memory clear sweep in progress.

Function
REQ-015 FSM states: INIT, RUN; reset enters INIT with sweep counter 0.
REQ-016 INIT: each cycle mem_we=1, mem_a=counter, mem_wd=0; counter increments by 1.
- After writing DEPTH-1: next state RUN, counter cleared.
- Sweep lasts exactly DEPTH cycles.
REQ-017 INIT: init_busy=1; c_gnt=d_gnt=0; requests are ignored but not lost (requesters hold req).
REQ-018 RUN: init_busy=0; at most one grant per cycle.
- gnt is combinational from req in the same cycle.
- Transaction accepted when req && gnt.
REQ-019 Arbitration is 2-way round-robin.
- One requester: it is granted.
- Both: grant goes to the port not granted last; last_grant pointer updates only on acceptance.
- After reset the pointer favours core (core wins the first tie).
REQ-020 Accepted in-range access (addr < DEPTH): mem_a=addr in the same cycle.
- Write: mem_we=1 and mem_wd=wdata in that cycle.
- Read: mem_rd is registered.
REQ-021 Read response: the granted port's rvalid=1 for exactly one cycle, the cycle after acceptance, with rdata = registered value; rdata holds its value while rvalid=0.
REQ-022 Writes produce no rvalid.
REQ-023 Out-of-range access (addr >= DEPTH): granted normally; mem_we=0.
- err=1 for one cycle, the cycle after acceptance.
- Out-of-range read also gives rvalid=1 with rdata=0.
REQ-024 No accepted access in RUN: mem_we=0, mem_a=0, mem_wd=0.
REQ-025 Write accepted in cycle N is visible to a read from either port accepted in cycle N+1.
REQ-026 A port requesting continuously is granted at least every second cycle.

Reset
REQ-027 rst=0 takes effect immediately, independent of clk.
- All outputs go to 0, including c_rdata/d_rdata.
- FSM=INIT, counter=0, last_grant=DMA.
REQ-028 Reset asserted mid-sweep or mid-transaction abandons it.
- Pending rvalid/err pulses are dropped.
- The sweep restarts from word 0 after rst returns to 1.
REQ-029 The first INIT write occurs on the first rising edge after rst deasserts.

Structure
REQ-030 Shared package dmem_arb_pkg holds: DEPTH default; the state encoding (INIT, RUN); the port id constants (PORT_CORE, PORT_DMA).
REQ-031 The round-robin decision is a sub-module rr_arb2 (req[1:0], last_grant -> gnt[1:0]); everything else is in data_mem_arbiter.

Verification
REQ-032 Release reset -> init_busy=1 for 256 cycles; mem_we=1 with mem_a 0..255 and mem_wd=0; then init_busy=0, mem_we=0.
REQ-033 Core writes 0x10 <- 0xDEADBEEF, then DMA reads 0x10 next cycle -> d_rvalid=1 one cycle later, d_rdata=0xDEADBEEF, c_rvalid=0.
REQ-034 Both ports hold read requests for 6 cycles after INIT -> grants C,D,C,D,C,D; each rvalid pulses one cycle after its grant.
REQ-035 DMA writes addr 0x100, data 0x1234 -> d_gnt=1, mem_we=0, d_err=1 next cycle; then a read of 0x100 -> d_rvalid=1, d_err=1, d_rdata=0.
REQ-036 Assert rst at sweep word 100 -> outputs 0 immediately; after release the sweep restarts at mem_a=0 and runs 256 cycles.
REQ-037 Core holds c_req during INIT -> c_gnt=0 throughout; c_gnt=1 in the first RUN cycle.
